// File: rtl/alu_slice_seq.sv
// SCAMP ALU slice: X/Y operand registers, six-bit-control ALU, flags latch.
// Optional bit-serial shifter on X is built when ALU_SHIFT_EN is defined.
module alu_slice_seq #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_bar,
    inout  wire  [WIDTH-1:0] bus,
    input  logic             XI_bar,
    input  logic             YI_bar,
    input  logic             EO_bar,
    input  logic             FL_bar,
    input  logic [5:0]       ALU_op,
    input  logic             carry_in,
    output logic             carry_out,
    output logic [WIDTH-1:0] E_val,
    output logic [WIDTH-1:0] X_val,
    output logic [WIDTH-1:0] Y_val,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n,
    input  logic             sh_start,
    input  logic [1:0]       sh_mode,
    input  logic [CW-1:0]    sh_amt,
    output logic             sh_busy,
    output logic             sh_done
);

    logic [WIDTH-1:0] x_q, y_q, e;
    logic [WIDTH-1:0] x1, x2, y1, y2, r;
    logic [WIDTH:0]   sum;
    logic             zx, nx, zy, ny, f, no;

    logic             sh_step, x_blk, c_load, sh_bit;
    logic [WIDTH-1:0] x_sh;

    assign {zx, nx, zy, ny, f, no} = ALU_op;

    always_comb begin
        x1  = zx ? '0 : x_q;
        x2  = nx ? ~x1 : x1;
        y1  = zy ? '0 : y_q;
        y2  = ny ? ~y1 : y1;
        sum = {1'b0, x2} + {1'b0, y2} + {{WIDTH{1'b0}}, carry_in};
        r   = f ? sum[WIDTH-1:0] : (x2 & y2);
        e   = no ? ~r : r;
    end

    // carry is taken from the raw sum, before the output inversion
    assign carry_out = f & sum[WIDTH];
    assign E_val     = e;
    assign X_val     = x_q;
    assign Y_val     = y_q;
    assign bus       = EO_bar ? {WIDTH{1'bz}} : e;

`ifdef ALU_SHIFT_EN
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, amt_c;
    logic [1:0]    mode_q, mode_d;
    logic          done_q, done_d;

    assign amt_c = (sh_amt > CW'(WIDTH)) ? CW'(WIDTH) : sh_amt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        x_blk   = 1'b0;
        sh_step = 1'b0;
        c_load  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sh_start) begin
                    x_blk = 1'b1;
                    if (amt_c == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                        cnt_d   = amt_c;
                        mode_d  = sh_mode;
                    end
                end
            end
            SHIFT: begin
                x_blk   = 1'b1;
                sh_step = 1'b1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    c_load  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_sh   = x_q;
        sh_bit = 1'b0;
        unique case (mode_q)
            2'b00: begin
                x_sh   = {x_q[WIDTH-2:0], 1'b0};
                sh_bit = x_q[WIDTH-1];
            end
            2'b01: begin
                x_sh   = {1'b0, x_q[WIDTH-1:1]};
                sh_bit = x_q[0];
            end
            2'b10: begin
                x_sh   = {x_q[WIDTH-1], x_q[WIDTH-1:1]};
                sh_bit = x_q[0];
            end
            default: begin
                x_sh   = {x_q[WIDTH-2:0], x_q[WIDTH-1]};
                sh_bit = x_q[WIDTH-1];
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 2'b00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign sh_busy = (state_q == SHIFT);
    assign sh_done = done_q;
`else
    logic unused_sh;

    assign unused_sh = ^{sh_start, sh_mode, sh_amt};
    assign sh_step   = 1'b0;
    assign x_blk     = 1'b0;
    assign c_load    = 1'b0;
    assign sh_bit    = 1'b0;
    assign x_sh      = '0;
    assign sh_busy   = 1'b0;
    assign sh_done   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            if (sh_step) begin
                x_q <= x_sh;
            end else if (!XI_bar && !x_blk) begin
                x_q <= bus;
            end
            if (!YI_bar) begin
                y_q <= bus;
            end
        end
    end

    // the shifter's final bit outranks a concurrent flag load for C
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            flag_z <= 1'b0;
            flag_c <= 1'b0;
            flag_n <= 1'b0;
        end else begin
            if (!FL_bar) begin
                flag_z <= (e == '0);
                flag_n <= e[WIDTH-1];
            end
            if (c_load) begin
                flag_c <= sh_bit;
            end else if (!FL_bar) begin
                flag_c <= carry_out;
            end
        end
    end

endmodule

// File: tb/tb_alu_slice_seq.sv
// Directed bench for alu_slice_seq at WIDTH=8.
// Shifter scenarios run when ALU_SHIFT_EN is defined, bypass checks otherwise.
module tb_alu_slice_seq;

    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          reset_bar = 1'b0;
    wire  [W-1:0]  bus;
    logic [W-1:0]  bus_drv = '0;
    logic          bus_en = 1'b0;
    logic          XI_bar = 1'b1, YI_bar = 1'b1;
    logic          EO_bar = 1'b1, FL_bar = 1'b1;
    logic [5:0]    ALU_op = 6'h00;
    logic          carry_in = 1'b0;
    logic          carry_out;
    logic [W-1:0]  E_val, X_val, Y_val;
    logic          flag_z, flag_c, flag_n;
    logic          sh_start = 1'b0;
    logic [1:0]    sh_mode = 2'b00;
    logic [CW-1:0] sh_amt = '0;
    logic          sh_busy, sh_done;

    int checks = 0;
    int failures = 0;

    assign bus = bus_en ? bus_drv : {W{1'bz}};

    alu_slice_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset_bar(reset_bar), .bus(bus),
        .XI_bar(XI_bar), .YI_bar(YI_bar), .EO_bar(EO_bar),
        .FL_bar(FL_bar), .ALU_op(ALU_op), .carry_in(carry_in),
        .carry_out(carry_out), .E_val(E_val), .X_val(X_val),
        .Y_val(Y_val), .flag_z(flag_z), .flag_c(flag_c),
        .flag_n(flag_n), .sh_start(sh_start), .sh_mode(sh_mode),
        .sh_amt(sh_amt), .sh_busy(sh_busy), .sh_done(sh_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_x(input logic [W-1:0] v);
        bus_en = 1'b1; bus_drv = v; XI_bar = 1'b0;
        tick();
        XI_bar = 1'b1; bus_en = 1'b0;
    endtask

    task automatic load_y(input logic [W-1:0] v);
        bus_en = 1'b1; bus_drv = v; YI_bar = 1'b0;
        tick();
        YI_bar = 1'b1; bus_en = 1'b0;
    endtask

    task automatic pulse_fl;
        FL_bar = 1'b0;
        tick();
        FL_bar = 1'b1;
    endtask

    task automatic shift_obs(input logic [1:0] m, input logic [CW-1:0] a,
                             input int n, output int busy_n,
                             output int done_n);
        sh_start = 1'b1; sh_mode = m; sh_amt = a;
        tick();
        sh_start = 1'b0;
        busy_n = 0;
        done_n = 0;
        for (int i = 0; i < n; i++) begin
            busy_n += int'(sh_busy);
            done_n += int'(sh_done);
            tick();
        end
    endtask

    int bn, dn;

    initial begin
        tick();
        tick();
        reset_bar = 1'b1;
        tick();
        check("rst_x", X_val, 8'h00);
        check("rst_y", Y_val, 8'h00);
        check("rst_flags", {flag_z, flag_c, flag_n}, 3'b000);
        check("rst_busy_done", {sh_busy, sh_done}, 2'b00);

        // add
        load_x(8'h5A);
        load_y(8'h33);
        ALU_op = 6'h02; carry_in = 1'b0;
        #1;
        check("add_x", X_val, 8'h5A);
        check("add_y", Y_val, 8'h33);
        check("add_e", E_val, 8'h8D);
        check("add_cout", carry_out, 1'b0);

        load_x(8'hFF);
        load_y(8'h01);
        #1;
        check("wrap_e", E_val, 8'h00);
        check("wrap_cout", carry_out, 1'b1);
        pulse_fl();
        check("wrap_flags", {flag_z, flag_c, flag_n}, 3'b110);

        // add with carry_in, negative result
        load_x(8'h80);
        carry_in = 1'b1;
        #1;
        check("addc_e", E_val, 8'h82);
        pulse_fl();
        check("addc_flags", {flag_z, flag_c, flag_n}, 3'b001);
        carry_in = 1'b0;

        // subtract and bus drive
        load_x(8'h10);
        ALU_op = 6'h13;
        #1;
        check("sub_e", E_val, 8'h0F);
        check("sub_cout", carry_out, 1'b0);
        EO_bar = 1'b0;
        #1;
        check("bus_drive", bus, 8'h0F);
        EO_bar = 1'b1;
        bus_en = 1'b1; bus_drv = 8'hA5;
        #1;
        check("bus_release", bus, 8'hA5);
        bus_en = 1'b0;

        // AND path ignores carry_in and never carries
        ALU_op = 6'h00; carry_in = 1'b1;
        load_x(8'hF3);
        load_y(8'h3C);
        #1;
        check("and_e", E_val, 8'h30);
        check("and_cout", carry_out, 1'b0);
        carry_in = 1'b0;

        // simultaneous X and Y load
        bus_en = 1'b1; bus_drv = 8'h6B; XI_bar = 1'b0; YI_bar = 1'b0;
        tick();
        XI_bar = 1'b1; YI_bar = 1'b1; bus_en = 1'b0;
        check("dual_load", {X_val, Y_val}, 16'h6B6B);

`ifdef ALU_SHIFT_EN
        // set C so a cleared flag_c after the shift is meaningful
        ALU_op = 6'h02;
        load_x(8'hFF);
        load_y(8'h01);
        pulse_fl();
        check("pre_c", flag_c, 1'b1);

        load_x(8'h81);
        shift_obs(2'b01, 4'd3, 6, bn, dn);
        check("lsr_x", X_val, 8'h10);
        check("lsr_busy_cycles", bn, 3);
        check("lsr_done_pulses", dn, 1);
        check("lsr_c", flag_c, 1'b0);

        load_x(8'h81);
        shift_obs(2'b10, 4'd3, 6, bn, dn);
        check("asr_x", X_val, 8'hF0);

        load_x(8'h81);
        shift_obs(2'b11, 4'd1, 4, bn, dn);
        check("rol_x", X_val, 8'h03);
        check("rol_c", flag_c, 1'b1);

        // amount above WIDTH clamps to WIDTH
        load_x(8'h81);
        load_y(8'h00);
        shift_obs(2'b00, 4'd15, 12, bn, dn);
        check("clamp_x", X_val, 8'h00);
        check("clamp_busy_cycles", bn, 8);
        check("clamp_c", flag_c, 1'b1);

        // exact latency, XI_bar and sh_start blocked while busy
        load_x(8'h81);
        sh_start = 1'b1; sh_mode = 2'b01; sh_amt = 4'd3;
        tick();
        check("lat_k_busy", {sh_busy, sh_done}, 2'b10);
        sh_amt = 4'd1;
        bus_en = 1'b1; bus_drv = 8'hAA; XI_bar = 1'b0;
        tick();
        check("lat_k1_x", X_val, 8'h40);
        tick();
        sh_start = 1'b0; XI_bar = 1'b1; bus_en = 1'b0;
        check("lat_k2_x", X_val, 8'h20);
        tick();
        check("lat_k3", {sh_busy, sh_done}, 2'b01);
        check("arb_x", X_val, 8'h10);
        tick();
        check("lat_k4", {sh_busy, sh_done}, 2'b00);

        // zero amount
        sh_start = 1'b1; sh_amt = 4'd0;
        tick();
        sh_start = 1'b0;
        check("zero_done", {sh_busy, sh_done}, 2'b01);
        check("zero_x", X_val, 8'h10);
        tick();
        check("zero_after", sh_done, 1'b0);

        // asynchronous reset mid-shift
        load_x(8'hFF);
        load_y(8'h01);
        pulse_fl();
        load_x(8'h81);
        sh_start = 1'b1; sh_mode = 2'b01; sh_amt = 4'd4;
        tick();
        sh_start = 1'b0;
        tick();
        tick();
        #2 reset_bar = 1'b0;
        #1;
        check("arst_xy", {X_val, Y_val}, 16'h0000);
        check("arst_flags", {flag_z, flag_c, flag_n}, 3'b000);
        check("arst_busy", sh_busy, 1'b0);
        #3 reset_bar = 1'b1;
        dn = 0;
        bn = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            dn += int'(sh_done);
            bn += int'(sh_busy);
        end
        check("arst_no_done", dn, 0);
        check("arst_no_busy", bn, 0);
`else
        load_x(8'h81);
        sh_start = 1'b1; sh_mode = 2'b01; sh_amt = 4'd4;
        tick();
        tick();
        check("nosh_x", X_val, 8'h81);
        check("nosh_busy_done", {sh_busy, sh_done}, 2'b00);
        tick();
        tick();
        check("nosh_x_later", X_val, 8'h81);
        check("nosh_done_later", sh_done, 1'b0);
        bus_en = 1'b1; bus_drv = 8'h3C; XI_bar = 1'b0;
        tick();
        XI_bar = 1'b1; bus_en = 1'b0; sh_start = 1'b0;
        check("nosh_xload", X_val, 8'h3C);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
